// File: rtl/tpu_tile_scheduler_if.sv
// Handshake, buffer-index and PE-control bundle between the TPU top level,
// the A/B/C buffers and the scheduler.
interface tpu_tile_scheduler_if #(
  parameter int DIM_W = 8,
  parameter int IDX_W = 16
);
  logic             in_valid;
  logic [DIM_W-1:0] K;
  logic [DIM_W-1:0] M;
  logic [DIM_W-1:0] N;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] A_index;
  logic [IDX_W-1:0] B_index;
  logic             pe_clear;
  logic             pe_shift_en;
  logic             pe_in_valid;
  logic [1:0]       c_row_sel;
  logic             C_wr_en;
  logic [IDX_W-1:0] C_index;

  modport slave (
    input  in_valid, K, M, N,
    output busy, done, A_index, B_index, pe_clear, pe_shift_en,
           pe_in_valid, c_row_sel, C_wr_en, C_index
  );

  modport master (
    output in_valid, K, M, N,
    input  busy, done, A_index, B_index, pe_clear, pe_shift_en,
           pe_in_valid, c_row_sel, C_wr_en, C_index
  );
endinterface

// File: rtl/tpu_tile_scheduler.sv
// Walks every 4x4 output tile of C = A*B, issuing buffer reads, PE controls and
// C write-back. All outputs are registered from the next-state decode.
module tpu_tile_scheduler #(
  parameter int ARRAY_DIM = 4,
  parameter int DIM_W     = 8,
  parameter int IDX_W     = 16,
  parameter int RD_LAT    = 1,
  parameter int DRAIN_CYC = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  tpu_tile_scheduler_if.slave bus
);
  localparam int ROW_W  = $clog2(ARRAY_DIM);
  localparam int TILE_W = DIM_W - ROW_W;
  localparam logic [DIM_W-1:0] DRAIN_LAST = DIM_W'(DRAIN_CYC + RD_LAT - 1);
  localparam logic [DIM_W-1:0] WRITE_LAST = DIM_W'(ARRAY_DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  state_e            r_state;
  state_e            w_nxt_state;
  logic [DIM_W-1:0]  r_cnt;
  logic [DIM_W-1:0]  w_nxt_cnt;
  logic [TILE_W-1:0] r_mt;
  logic [TILE_W-1:0] r_nt;
  logic [TILE_W-1:0] w_nxt_mt;
  logic [TILE_W-1:0] w_nxt_nt;
  logic [DIM_W-1:0]  r_k;
  logic [DIM_W-1:0]  r_m;
  logic [DIM_W-1:0]  r_n;
  logic              w_accept;
  logic [TILE_W-1:0] w_mt_last;
  logic [TILE_W-1:0] w_nt_last;

  logic              w_busy;
  logic              w_done;
  logic              w_pe_clear;
  logic [IDX_W-1:0]  w_a_index;
  logic [IDX_W-1:0]  w_b_index;
  logic [1:0]        w_row_sel;
  logic              w_c_wr_en;
  logic [IDX_W-1:0]  w_c_index;
  logic [DIM_W-1:0]  w_tile_row;

  logic              r_busy;
  logic              r_done;
  logic              r_pe_clear;
  logic              r_pe_shift;
  logic [IDX_W-1:0]  r_a_index;
  logic [IDX_W-1:0]  r_b_index;
  logic [1:0]        r_row_sel;
  logic              r_c_wr_en;
  logic [IDX_W-1:0]  r_c_index;
  // Bit 0 mirrors "state is FEED"; bit RD_LAT is that flag after the buffer latency.
  logic [RD_LAT:0]   r_feed_dly;

  assign w_mt_last = TILE_W'((r_m - DIM_W'(1)) >> ROW_W);
  assign w_nt_last = TILE_W'((r_n - DIM_W'(1)) >> ROW_W);

  // State, phase counter and tile coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mt    <= '0;
      r_nt    <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_mt    <= w_nxt_mt;
      r_nt    <= w_nxt_nt;
    end
  end

  // Job dimensions, captured only when a job is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k <= '0;
      r_m <= '0;
      r_n <= '0;
    end else if (w_accept) begin
      r_k <= bus.K;
      r_m <= bus.M;
      r_n <= bus.N;
    end
  end

  // Next-state logic; a zero dimension completes the job without touching buffers.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_mt    = r_mt;
    w_nxt_nt    = r_nt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          if ((bus.K != '0) && (bus.M != '0) && (bus.N != '0)) begin
            w_accept    = 1'b1;
            w_nxt_state = S_CLEAR;
            w_nxt_cnt   = '0;
            w_nxt_mt    = '0;
            w_nxt_nt    = '0;
          end else begin
            w_nxt_state = S_FIN;
          end
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_nxt_state = S_FEED;
        w_nxt_cnt   = '0;
      end
      S_FEED: begin
        if (r_cnt == (r_k - DIM_W'(1))) begin
          w_nxt_state = S_DRAIN;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + DIM_W'(1);
        end
      end
      S_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_nxt_state = S_WRITE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + DIM_W'(1);
        end
      end
      S_WRITE: begin
        if (r_cnt == WRITE_LAST) begin
          w_nxt_cnt = '0;
          if (r_nt == w_nt_last) begin
            w_nxt_nt = '0;
            if (r_mt == w_mt_last) begin
              w_nxt_state = S_FIN;
            end else begin
              w_nxt_mt    = r_mt + TILE_W'(1);
              w_nxt_state = S_CLEAR;
            end
          end else begin
            w_nxt_nt    = r_nt + TILE_W'(1);
            w_nxt_state = S_CLEAR;
          end
        end else begin
          w_nxt_cnt = r_cnt + DIM_W'(1);
        end
      end
      S_FIN: begin
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // mt*ARRAY_DIM + r is just the concatenation of the tile row and row-in-tile.
  assign w_tile_row = {w_nxt_mt, w_nxt_cnt[ROW_W-1:0]};

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_pe_clear = 1'b0;
    w_a_index  = '0;
    w_b_index  = '0;
    w_row_sel  = 2'd0;
    w_c_wr_en  = 1'b0;
    w_c_index  = '0;
    case (w_nxt_state)
      S_CLEAR: begin
        w_busy     = 1'b1;
        w_pe_clear = 1'b1;
      end
      S_FEED: begin
        w_busy    = 1'b1;
        w_a_index = IDX_W'(w_nxt_mt) * IDX_W'(r_k) + IDX_W'(w_nxt_cnt);
        w_b_index = IDX_W'(w_nxt_nt) * IDX_W'(r_k) + IDX_W'(w_nxt_cnt);
      end
      S_DRAIN: begin
        w_busy = 1'b1;
      end
      S_WRITE: begin
        w_busy    = 1'b1;
        w_row_sel = 2'(w_nxt_cnt[ROW_W-1:0]);
        w_c_wr_en = (w_tile_row < r_m);
        w_c_index = IDX_W'(w_nxt_nt) * IDX_W'(r_m) + IDX_W'(w_tile_row);
      end
      S_FIN: begin
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Registered outputs; the shift enable spans delayed FEED plus the whole DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pe_clear <= 1'b0;
      r_pe_shift <= 1'b0;
      r_a_index  <= '0;
      r_b_index  <= '0;
      r_row_sel  <= 2'd0;
      r_c_wr_en  <= 1'b0;
      r_c_index  <= '0;
      r_feed_dly <= '0;
    end else begin
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_pe_clear <= w_pe_clear;
      r_pe_shift <= (w_nxt_state == S_DRAIN) | r_feed_dly[RD_LAT-1];
      r_a_index  <= w_a_index;
      r_b_index  <= w_b_index;
      r_row_sel  <= w_row_sel;
      r_c_wr_en  <= w_c_wr_en;
      r_c_index  <= w_c_index;
      r_feed_dly <= {r_feed_dly[RD_LAT-1:0], (w_nxt_state == S_FEED)};
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pe_clear    = r_pe_clear;
  assign bus.pe_shift_en = r_pe_shift;
  assign bus.pe_in_valid = r_feed_dly[RD_LAT];
  assign bus.A_index     = r_a_index;
  assign bus.B_index     = r_b_index;
  assign bus.c_row_sel   = r_row_sel;
  assign bus.C_wr_en     = r_c_wr_en;
  assign bus.C_index     = r_c_index;
endmodule
